// File: rtl/iq_fe_pkg.sv
// iq_fe_pkg: shared ADC widths, sample types and FSM states for the I/Q front end.
package iq_fe_pkg;
    localparam int ADC_W   = 12;
    localparam int ADC_MID = 2048;
    typedef logic signed [ADC_W-1:0] adc_s_t;
    typedef logic signed [ADC_W:0]   dcout_t;
    typedef enum logic {WARMUP, RUN} fe_state_t;
    function automatic adc_s_t to_signed(input logic [ADC_W-1:0] s);
        return {~s[ADC_W-1], s[ADC_W-2:0]};
    endfunction
endpackage

// File: rtl/iq_dc_block.sv
// iq_dc_block: one channel of offset-binary to signed conversion plus DC-removing IIR with bypass.
module iq_dc_block
    import iq_fe_pkg::*;
#(
    parameter int DC_SHIFT = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             bypass,
    input  logic [ADC_W-1:0] raw,
    output dcout_t           y
);
    logic signed [ADC_W+DC_SHIFT:0] acc;
    adc_s_t x;
    dcout_t xe, est, y_n;
    assign x   = to_signed(raw);
    assign xe  = {x[ADC_W-1], x};
    assign est = acc[ADC_W+DC_SHIFT:DC_SHIFT];
    assign y_n = bypass ? xe : xe - est;
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            y   <= '0;
        end else if (en) begin
            y <= y_n;
            if (!bypass) acc <= acc + (ADC_W+1+DC_SHIFT)'(y_n);
        end
    end
endmodule

// File: rtl/iq_frontend_decim.sv
// iq_frontend_decim: syncs the ADC strobe, removes DC per channel and averages-and-dumps
// by 2^DEC_LOG2 into saturated signed I/Q pairs after a warm-up period.
module iq_frontend_decim
    import iq_fe_pkg::*;
#(
    parameter int DC_SHIFT  = 10,
    parameter int DEC_LOG2  = 2,
    parameter int WARM_LOG2 = 8,
    parameter int OUT_W     = 12
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [ADC_W-1:0] msi_i,
    input  logic [ADC_W-1:0] msi_q,
    input  logic             data_clk,
    input  logic             dc_bypass,
    output logic [OUT_W-1:0] iq_i,
    output logic [OUT_W-1:0] iq_q,
    output logic             iq_valid,
    output logic             sat_flag
);
    localparam int SUM_W = ADC_W + 1 + DEC_LOG2;
    localparam int MAXV  = (1 << (OUT_W - 1)) - 1;
    localparam int MINV  = -MAXV - 1;
    localparam logic [DEC_LOG2:0]  DEC_LAST  = (DEC_LOG2+1)'((1 << DEC_LOG2) - 1);
    localparam logic [WARM_LOG2:0] WARM_LAST = (WARM_LOG2+1)'((1 << WARM_LOG2) - 1);

    fe_state_t state, state_n;
    logic s1, s2, s3, strobe, v1, v2, last, warm_done;
    logic [ADC_W-1:0] raw_i, raw_q;
    logic [DEC_LOG2:0] cnt;
    logic [WARM_LOG2:0] wcnt;
    dcout_t y_i, y_q;
    logic signed [SUM_W-1:0] sum_i, sum_q, tot_i, tot_q;
    logic [OUT_W:0] c_i, c_q;

    // {saturated, value}
    function automatic logic [OUT_W:0] clamp(input dcout_t a);
        return int'(a) > MAXV ? {1'b1, OUT_W'(MAXV)} :
               int'(a) < MINV ? {1'b1, OUT_W'(MINV)} : {1'b0, OUT_W'(a)};
    endfunction

    assign strobe = s2 & ~s3;
    assign last   = cnt == DEC_LAST;
    assign tot_i  = sum_i + SUM_W'(y_i);
    assign tot_q  = sum_q + SUM_W'(y_q);
    assign c_i    = clamp(tot_i[SUM_W-1:DEC_LOG2]);
    assign c_q    = clamp(tot_q[SUM_W-1:DEC_LOG2]);

    iq_dc_block #(.DC_SHIFT(DC_SHIFT)) u_dc_i (
        .clk(CLK), .rst(RST), .en(v1), .bypass(dc_bypass), .raw(raw_i), .y(y_i)
    );
    iq_dc_block #(.DC_SHIFT(DC_SHIFT)) u_dc_q (
        .clk(CLK), .rst(RST), .en(v1), .bypass(dc_bypass), .raw(raw_q), .y(y_q)
    );

    always_ff @(posedge CLK) begin
        if (RST) state <= WARMUP;
        else     state <= state_n;
    end

    always_comb begin
        warm_done = state == WARMUP && v2 && wcnt == WARM_LAST;
        state_n   = warm_done ? RUN : state;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            {s1, s2, s3, v1, v2} <= '0;
            raw_i    <= '0;
            raw_q    <= '0;
            sum_i    <= '0;
            sum_q    <= '0;
            cnt      <= '0;
            wcnt     <= '0;
            iq_i     <= '0;
            iq_q     <= '0;
            iq_valid <= 1'b0;
            sat_flag <= 1'b0;
        end else begin
            s1       <= data_clk;
            s2       <= s1;
            s3       <= s2;
            v1       <= strobe;
            v2       <= v1;
            iq_valid <= 1'b0;
            if (strobe) begin
                raw_i <= msi_i;
                raw_q <= msi_q;
            end
            if (v2) begin
                if (state == WARMUP) wcnt <= wcnt + 1'b1;
                // the block boundary realigns at warm-up exit so the first output is a full block
                if (warm_done || last) begin
                    sum_i <= '0;
                    sum_q <= '0;
                    cnt   <= '0;
                end else begin
                    sum_i <= tot_i;
                    sum_q <= tot_q;
                    cnt   <= cnt + 1'b1;
                end
                if (!warm_done && last && state == RUN) begin
                    iq_i     <= c_i[OUT_W-1:0];
                    iq_q     <= c_q[OUT_W-1:0];
                    iq_valid <= 1'b1;
                    sat_flag <= sat_flag | c_i[OUT_W] | c_q[OUT_W];
                end
            end
        end
    end
endmodule

// File: tb/tb_iq_frontend_decim.sv
// tb_iq_frontend_decim: directed vectors checked against a pair-level arithmetic model for
// two instances that differ only in output width (12 and 8 bits).
module tb_iq_frontend_decim;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic [11:0] msi_i = 12'd2048;
    logic [11:0] msi_q = 12'd2048;
    logic data_clk = 1'b0;
    logic dc_bypass = 1'b0;
    logic [11:0] a_i, a_q;
    logic [7:0] b_i, b_q;
    logic a_v, b_v, a_s, b_s;

    always #5 CLK = ~CLK;

    iq_frontend_decim #(.DC_SHIFT(4), .DEC_LOG2(2), .WARM_LOG2(8), .OUT_W(12)) dut_a (
        .CLK(CLK), .RST(RST), .msi_i(msi_i), .msi_q(msi_q), .data_clk(data_clk),
        .dc_bypass(dc_bypass), .iq_i(a_i), .iq_q(a_q), .iq_valid(a_v), .sat_flag(a_s)
    );
    iq_frontend_decim #(.DC_SHIFT(4), .DEC_LOG2(2), .WARM_LOG2(8), .OUT_W(8)) dut_b (
        .CLK(CLK), .RST(RST), .msi_i(msi_i), .msi_q(msi_q), .data_clk(data_clk),
        .dc_bypass(dc_bypass), .iq_i(b_i), .iq_q(b_q), .iq_valid(b_v), .sat_flag(b_s)
    );

    typedef struct {int i; int q; bit s;} exp_t;
    exp_t qa[$], qb[$];
    int checks = 0, failures = 0;
    int m_acc_i, m_acc_q, m_sum_i, m_sum_q, m_cnt, m_pairs;
    bit m_run, m_sat_a, m_sat_b;
    int ea_i, ea_q, eb_i, eb_q;
    bit ea_s, eb_s;
    int va, vb, last_ai, last_aq, last_bi, last_bq;

    task automatic check(input string n, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", n, act, exp);
        end
    endtask

    function automatic int clampw(input int v, input int w);
        int hi = (1 << (w - 1)) - 1;
        return v > hi ? hi : (v < -hi - 1 ? -hi - 1 : v);
    endfunction

    task automatic model_reset();
        {m_acc_i, m_acc_q, m_sum_i, m_sum_q, m_cnt, m_pairs} = '0;
        {m_run, m_sat_a, m_sat_b} = '0;
        {ea_i, ea_q, eb_i, eb_q} = '0;
        {ea_s, eb_s} = '0;
        qa.delete();
        qb.delete();
    endtask

    task automatic model_pair();
        int xi, xq, yi, yq, avi, avq;
        exp_t e;
        xi = int'(msi_i) - 2048;
        xq = int'(msi_q) - 2048;
        yi = dc_bypass ? xi : xi - (m_acc_i >>> 4);
        yq = dc_bypass ? xq : xq - (m_acc_q >>> 4);
        if (!dc_bypass) begin
            m_acc_i += yi;
            m_acc_q += yq;
        end
        m_pairs++;
        if (!m_run) begin
            if (m_pairs == 256) begin
                m_run = 1;
                m_cnt = 0;
                m_sum_i = 0;
                m_sum_q = 0;
            end
        end else begin
            m_sum_i += yi;
            m_sum_q += yq;
            m_cnt++;
            if (m_cnt == 4) begin
                avi = m_sum_i >>> 2;
                avq = m_sum_q >>> 2;
                e.i = clampw(avi, 12);
                e.q = clampw(avq, 12);
                m_sat_a |= (e.i != avi) || (e.q != avq);
                e.s = m_sat_a;
                qa.push_back(e);
                e.i = clampw(avi, 8);
                e.q = clampw(avq, 8);
                m_sat_b |= (e.i != avi) || (e.q != avq);
                e.s = m_sat_b;
                qb.push_back(e);
                m_cnt = 0;
                m_sum_i = 0;
                m_sum_q = 0;
            end
        end
    endtask

    always @(negedge CLK) begin : cmp
        exp_t e;
        if (!RST) begin
            if (a_v) begin
                va++;
                last_ai = $signed(a_i);
                last_aq = $signed(a_q);
                if (qa.size() == 0) check("a_spurious_valid", a_v, 0);
                else begin
                    e = qa.pop_front();
                    {ea_i, ea_q, ea_s} = {e.i, e.q, e.s};
                end
            end
            if (b_v) begin
                vb++;
                last_bi = $signed(b_i);
                last_bq = $signed(b_q);
                if (qb.size() == 0) check("b_spurious_valid", b_v, 0);
                else begin
                    e = qb.pop_front();
                    {eb_i, eb_q, eb_s} = {e.i, e.q, e.s};
                end
            end
            check("a_iq_i", $signed(a_i), ea_i);
            check("a_iq_q", $signed(a_q), ea_q);
            check("a_sat", a_s, ea_s);
            check("b_iq_i", $signed(b_i), eb_i);
            check("b_iq_q", $signed(b_q), eb_q);
            check("b_sat", b_s, eb_s);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #2;
    endtask

    task automatic pair(input int i, input int q);
        msi_i = 12'(i);
        msi_q = 12'(q);
        data_clk = 1'b1;
        model_pair();
        tick(2);
        data_clk = 1'b0;
        tick(2);
    endtask

    task automatic check_reset_state(input string n);
        check({n, "_a_i"}, $signed(a_i), 0);
        check({n, "_a_q"}, $signed(a_q), 0);
        check({n, "_a_v"}, a_v, 0);
        check({n, "_a_sat"}, a_s, 0);
        check({n, "_b_sat"}, b_s, 0);
        check({n, "_b_i"}, $signed(b_i), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        data_clk = 1'b1;
        tick(3);
        RST = 1'b0;
        va = 0;
        vb = 0;
        check_reset_state("reset");
        model_pair();
        tick(4);
        data_clk = 1'b0;
        tick(2);
        for (int k = 0; k < 255; k++) pair(2048, 2048);
        tick(8);
        check("warmup_no_valid", va, 0);
        for (int k = 0; k < 40; k++) pair(2048, 2048);
        tick(8);
        check("dc_zero_valid_count", va, 10);
        check("dc_zero_i", last_ai, 0);
        check("dc_zero_q", last_aq, 0);
        check("b_sat_before_clip", b_s, 0);

        dc_bypass = 1'b1;
        tick(4);
        for (int k = 1; k <= 4; k++) pair(2048 + 4 * k, 0);
        tick(8);
        check("avg_ramp_i", last_ai, 10);
        check("avg_min_q", last_aq, -2048);
        check("avg_ramp_b_i", last_bi, 10);
        check("clip_b_q", last_bq, -128);
        check("clip_b_sat", b_s, 1);
        check("noclip_a_sat", a_s, 0);

        for (int k = 0; k < 4; k++) pair(3072, 2048);
        tick(8);
        check("bypass_offset_i", last_ai, 1024);
        dc_bypass = 1'b0;
        tick(4);
        for (int k = 0; k < 128; k++) pair(3072, 2048);
        tick(8);
        check("dc_decay_small", int'(last_ai < 8 && last_ai > -8), 1);
        check("dc_decay_q", last_aq, 0);

        pair(2100, 1900);
        pair(2200, 1800);
        tick(8);
        RST = 1'b1;
        model_reset();
        tick(1);
        RST = 1'b0;
        va = 0;
        vb = 0;
        check_reset_state("midrst");
        for (int k = 0; k < 1000; k++) begin
            pair(2048 + ((k * 37) % 1024) - 512, 2048 + ((k * 91) % 2000) - 1000);
            if (k == 258) begin
                tick(8);
                check("midrst_no_early_valid", va, 0);
            end
        end
        tick(8);
        check("spacing4_valid_count_a", va, 186);
        check("spacing4_valid_count_b", vb, 186);
        check("queue_drained_a", qa.size(), 0);
        check("queue_drained_b", qb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
